// File: rtl/noc_sched_pkg.sv
// Shared definitions for the 4-port NOC switch transfer scheduler:
// port indices, FSM state encoding and a one-hot helper.
package noc_sched_pkg;

    localparam int NPORT = 4;
    localparam int IDX_W = 2;

    localparam logic [IDX_W-1:0] PORT_A = 2'd0;
    localparam logic [IDX_W-1:0] PORT_B = 2'd1;
    localparam logic [IDX_W-1:0] PORT_C = 2'd2;
    localparam logic [IDX_W-1:0] PORT_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CFG     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    function automatic logic [NPORT-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NPORT-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick: first requester at or after ptr,
// scanning upward modulo 4.
module rr_arbiter4
    import noc_sched_pkg::*;
(
    input  logic [NPORT-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win_idx,
    output logic             any_req
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        win_idx = ptr;
        any_req = |req;
        // Walk from the farthest offset down so the nearest requester is written last and wins.
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (req[ptr + IDX_W'(i)]) begin
                win_idx = ptr + IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/noc_rr_scheduler.sv
// Round-robin transfer scheduler: picks a source port, latches its request,
// and sequences CNFG / LOAD / enables of the NOC switch for one burst.
module noc_rr_scheduler
    import noc_sched_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic                   CLK,
    input  logic                   RES,
    input  logic [NPORT-1:0]       req,
    input  logic [NPORT*IDX_W-1:0] req_dest,
    input  logic [NPORT*LEN_W-1:0] req_len,
    output logic [NPORT-1:0]       gnt,
    output logic [IDX_W-1:0]       In_add,
    output logic [IDX_W-1:0]       out_add,
    output logic                   CNFG,
    output logic                   LOAD,
    output logic [NPORT-1:0]       en,
    output logic                   busy,
    output logic                   done
);

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] dest;
    logic [LEN_W-1:0] cnt;
    logic [IDX_W-1:0] arb_win;
    logic             arb_any;

    rr_arbiter4 u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .win_idx (arb_win),
        .any_req (arb_any)
    );

    // NOTE: all state and outputs update with non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            win_idx <= '0;
            dest    <= '0;
            cnt     <= '0;
            gnt     <= '0;
            In_add  <= '0;
            out_add <= '0;
            CNFG    <= 1'b0;
            LOAD    <= 1'b0;
            en      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        win_idx <= arb_win;
                        dest    <= req_dest[IDX_W*arb_win +: IDX_W];
                        cnt     <= req_len[LEN_W*arb_win +: LEN_W];
                        gnt     <= onehot(arb_win);
                        In_add  <= arb_win;
                        out_add <= req_dest[IDX_W*arb_win +: IDX_W];
                        CNFG    <= 1'b1;
                        busy    <= 1'b1;
                        state   <= CFG;
                    end
                end
                CFG: begin
                    CNFG  <= 1'b0;
                    LOAD  <= 1'b1;
                    en    <= onehot(dest);
                    state <= XFER;
                end
                XFER: begin
                    // cnt starts at len, so exit on zero gives len+1 load cycles.
                    if (cnt == '0) begin
                        LOAD  <= 1'b0;
                        en    <= '0;
                        gnt   <= '0;
                        done  <= 1'b1;
                        state <= RELEASE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    In_add  <= '0;
                    out_add <= '0;
                    rr_ptr  <= win_idx + 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_rr_scheduler.sv
// Self-checking bench for noc_rr_scheduler: scenario tasks with inline checks
// plus a burst monitor that compares each finished burst against a scoreboard.
module tb_noc_rr_scheduler;

    localparam int LEN_W = 4;

    logic               CLK = 1'b0;
    logic               RES;
    logic [3:0]         req;
    logic [7:0]         req_dest;
    logic [4*LEN_W-1:0] req_len;
    logic [3:0]         gnt;
    logic [1:0]         In_add;
    logic [1:0]         out_add;
    logic               CNFG;
    logic               LOAD;
    logic [3:0]         en;
    logic               busy;
    logic               done;

    noc_rr_scheduler #(.LEN_W(LEN_W)) dut (
        .CLK      (CLK),
        .RES      (RES),
        .req      (req),
        .req_dest (req_dest),
        .req_len  (req_len),
        .gnt      (gnt),
        .In_add   (In_add),
        .out_add  (out_add),
        .CNFG     (CNFG),
        .LOAD     (LOAD),
        .en       (en),
        .busy     (busy),
        .done     (done)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int src;
        int dest;
        int flits;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   in_burst = 1'b0;
    int   obs_src, obs_dest, load_cnt;

    // Burst monitor: observes CFG/XFER/RELEASE on the falling edge.
    always @(negedge CLK) begin
        if (RES !== 1'b0) begin
            in_burst = 1'b0;
        end else begin
            checks++;
            if ($isunknown({gnt, en, CNFG}) || $countones(gnt) > 1 || $countones(en) > 1) begin
                errors++;
                $display("FAIL onehot_x: gnt=%b en=%b CNFG=%b, required at most one-hot and no X", gnt, en, CNFG);
            end
            if (CNFG === 1'b1) begin
                checks++;
                if (gnt !== (4'b0001 << In_add)) begin
                    errors++;
                    $display("FAIL cfg_gnt: gnt=%b In_add=%0d, required gnt one-hot of In_add", gnt, In_add);
                end
                in_burst = 1'b1;
                obs_src  = int'(In_add);
                obs_dest = int'(out_add);
                load_cnt = 0;
            end
            if (LOAD === 1'b1) begin
                load_cnt++;
                checks++;
                if (!in_burst || en !== (4'b0001 << obs_dest) || gnt !== (4'b0001 << obs_src)) begin
                    errors++;
                    $display("FAIL xfer_lines: en=%b gnt=%b, required en=%b gnt=%b", en, gnt,
                             4'b0001 << obs_dest, 4'b0001 << obs_src);
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_done: done=1, required no burst completion");
                end else begin
                    mon_e = sb.pop_front();
                    if (!in_burst || obs_src != mon_e.src || obs_dest != mon_e.dest || load_cnt != mon_e.flits) begin
                        errors++;
                        $display("FAIL sb_burst: src=%0d dest=%0d flits=%0d, required src=%0d dest=%0d flits=%0d",
                                 obs_src, obs_dest, load_cnt, mon_e.src, mon_e.dest, mon_e.flits);
                    end
                end
                in_burst = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input int s, input int d, input int l);
        exp_t e;
        e.src   = s;
        e.dest  = d;
        e.flits = l + 1;
        sb.push_back(e);
    endtask

    task automatic set_port(input int p, input int d, input int l);
        req_dest[2*p +: 2]         = d[1:0];
        req_len[LEN_W*p +: LEN_W]  = l[LEN_W-1:0];
    endtask

    // Waits (bounded) for: 0 = CNFG high, 1 = done high, 2 = busy low.
    task automatic wait_for(input int sel, output int waited);
        logic hit;
        waited = 0;
        do begin
            tick();
            waited++;
            hit = (sel == 0) ? (CNFG === 1'b1) : (sel == 1) ? (done === 1'b1) : (busy === 1'b0);
        end while (!hit && waited < 60);
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_for: event %0d not seen after %0d cycles, required within 60", sel, waited);
        end
    endtask

    task automatic test_reset();
        int t;
        RES = 1'b1;
        req = 4'b1111;
        for (int p = 0; p < 4; p++) set_port(p, 3, 0);
        tick();
        tick();
        checks++;
        if ({gnt, en, In_add, out_add, CNFG, LOAD, busy, done} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b en=%b In=%0d out=%0d CNFG=%b LOAD=%b busy=%b done=%b, required all 0",
                     gnt, en, In_add, out_add, CNFG, LOAD, busy, done);
        end
        push_exp(0, 3, 0);
        RES = 1'b0;
        tick();
        checks++;
        if (CNFG !== 1'b1 || gnt !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: CNFG=%b gnt=%b busy=%b, required 1 0001 1", CNFG, gnt, busy);
        end
        req = 4'b0000;
        wait_for(2, t);
    endtask

    task automatic test_single_burst();
        set_port(2, 1, 2);
        push_exp(2, 1, 2);
        req = 4'b0100;
        tick();
        checks++;
        if (CNFG !== 1'b1 || In_add !== 2'd2 || out_add !== 2'd1 || gnt !== 4'b0100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_cfg: CNFG=%b In=%0d out=%0d gnt=%b busy=%b, required 1 2 1 0100 1",
                     CNFG, In_add, out_add, gnt, busy);
        end
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (LOAD !== 1'b1 || en !== 4'b0010 || CNFG !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL single_xfer%0d: LOAD=%b en=%b CNFG=%b done=%b, required 1 0010 0 0", i, LOAD, en, CNFG, done);
            end
        end
        tick();
        checks++;
        if (done !== 1'b1 || LOAD !== 1'b0 || en !== 4'b0000 || gnt !== 4'b0000 || In_add !== 2'd2 || out_add !== 2'd1) begin
            errors++;
            $display("FAIL single_release: done=%b LOAD=%b en=%b gnt=%b In=%0d out=%0d, required 1 0 0000 0000 2 1",
                     done, LOAD, en, gnt, In_add, out_add);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_fairness();
        int t;
        logic [3:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        RES = 1'b1;
        tick();
        RES = 1'b0;
        set_port(0, 1, 0);
        set_port(1, 2, 0);
        set_port(2, 3, 0);
        set_port(3, 0, 0);
        push_exp(0, 1, 0);
        push_exp(1, 2, 0);
        push_exp(2, 3, 0);
        push_exp(3, 0, 0);
        push_exp(0, 1, 0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_for(0, t);
            checks++;
            if (gnt !== exp_g[k]) begin
                errors++;
                $display("FAIL fair_gnt%0d: gnt=%b, required %b", k, gnt, exp_g[k]);
            end
            if (k > 0) begin
                checks++;
                if (t != 4) begin
                    errors++;
                    $display("FAIL fair_spacing%0d: CFG gap=%0d cycles, required 4", k, t);
                end
            end
        end
        req = 4'b0000;
        wait_for(2, t);
    endtask

    task automatic test_wrap_skip();
        int t;
        set_port(3, 2, 0);
        push_exp(3, 2, 0);
        req = 4'b1000;
        wait_for(0, t);
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_d: gnt=%b, required 1000", gnt);
        end
        req = 4'b0000;
        wait_for(2, t);
        set_port(1, 0, 1);
        set_port(2, 3, 0);
        push_exp(1, 0, 1);
        push_exp(2, 3, 0);
        req = 4'b0110;
        wait_for(0, t);
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_b_first: gnt=%b, required 0010", gnt);
        end
        wait_for(0, t);
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL skip_c_next: gnt=%b, required 0100", gnt);
        end
        req = 4'b0000;
        wait_for(2, t);
    endtask

    task automatic test_reset_mid();
        int t;
        set_port(0, 2, 7);
        req = 4'b0001;
        tick();
        checks++;
        if (CNFG !== 1'b1 || gnt !== 4'b0001) begin
            errors++;
            $display("FAIL mid_cfg: CNFG=%b gnt=%b, required 1 0001", CNFG, gnt);
        end
        req = 4'b0000;
        tick();
        tick();
        tick();
        checks++;
        if (LOAD !== 1'b1 || en !== 4'b0100) begin
            errors++;
            $display("FAIL mid_xfer3: LOAD=%b en=%b, required 1 0100", LOAD, en);
        end
        RES = 1'b1;
        tick();
        checks++;
        if ({gnt, en, In_add, out_add, CNFG, LOAD, busy, done} !== 16'h0) begin
            errors++;
            $display("FAIL mid_abort: gnt=%b en=%b In=%0d out=%0d CNFG=%b LOAD=%b busy=%b done=%b, required all 0",
                     gnt, en, In_add, out_add, CNFG, LOAD, busy, done);
        end
        RES = 1'b0;
        for (int p = 0; p < 4; p++) set_port(p, 1, 0);
        push_exp(0, 1, 0);
        req = 4'b1111;
        wait_for(0, t);
        checks++;
        if (gnt !== 4'b0001 || t != 1) begin
            errors++;
            $display("FAIL mid_next_from_a: gnt=%b after %0d cycles, required 0001 after 1", gnt, t);
        end
        req = 4'b0000;
        wait_for(2, t);
    endtask

    task automatic test_drop_loopback();
        set_port(0, 0, 1);
        push_exp(0, 0, 1);
        req = 4'b0001;
        tick();
        checks++;
        if (CNFG !== 1'b1 || gnt !== 4'b0001 || In_add !== 2'd0 || out_add !== 2'd0) begin
            errors++;
            $display("FAIL loop_cfg: CNFG=%b gnt=%b In=%0d out=%0d, required 1 0001 0 0", CNFG, gnt, In_add, out_add);
        end
        req = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (LOAD !== 1'b1 || en !== 4'b0001 || gnt !== 4'b0001) begin
                errors++;
                $display("FAIL loop_xfer%0d: LOAD=%b en=%b gnt=%b, required 1 0001 0001", i, LOAD, en, gnt);
            end
        end
        tick();
        checks++;
        if (done !== 1'b1 || LOAD !== 1'b0 || en !== 4'b0000) begin
            errors++;
            $display("FAIL loop_release: done=%b LOAD=%b en=%b, required 1 0 0000", done, LOAD, en);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL loop_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_max_len_release_req();
        int t;
        set_port(1, 3, 15);
        push_exp(1, 3, 15);
        req = 4'b0010;
        wait_for(0, t);
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL max_cfg: gnt=%b, required 0010", gnt);
        end
        set_port(1, 0, 2);
        req = 4'b0000;
        wait_for(1, t);
        checks++;
        if (t != 17 || In_add !== 2'd1 || out_add !== 2'd3) begin
            errors++;
            $display("FAIL max_release: done after %0d cycles In=%0d out=%0d, required 17 1 3", t, In_add, out_add);
        end
        set_port(0, 1, 0);
        push_exp(0, 1, 0);
        req = 4'b0001;
        tick();
        checks++;
        if (busy !== 1'b0 || CNFG !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL release_req_idle: busy=%b CNFG=%b gnt=%b, required 0 0 0000", busy, CNFG, gnt);
        end
        tick();
        checks++;
        if (CNFG !== 1'b1 || gnt !== 4'b0001) begin
            errors++;
            $display("FAIL release_req_grant: CNFG=%b gnt=%b, required 1 0001", CNFG, gnt);
        end
        req = 4'b0000;
        wait_for(2, t);
    endtask

    initial begin
        RES      = 1'b1;
        req      = 4'b0000;
        req_dest = 8'h00;
        req_len  = '0;
        test_reset();
        test_single_burst();
        test_fairness();
        test_wrap_skip();
        test_reset_mid();
        test_drop_loopback();
        test_max_len_release_req();
        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d bursts outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
